// File: rtl/det_pkg.sv
// Shared types for the determinant engine and its loader: dimensions, element/matrix
// types and the one-hot loader state encoding.
package det_pkg;
    localparam int N     = 8;
    localparam int W     = 32;
    localparam int IDX_W = $clog2(N);

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t [N-1:0][N-1:0] matrix_t;

    typedef enum logic [4:0] {
        ST_LOAD   = 5'b00001,
        ST_START  = 5'b00010,
        ST_WAIT   = 5'b00100,
        ST_RESULT = 5'b01000,
        ST_ACK    = 5'b10000
    } state_t;
endpackage

// File: rtl/det_fill_counter.sv
// Row-major fill position for the loader: a 6-bit element counter split into row/col,
// with a flag marking the final element of the matrix.
module det_fill_counter
    import det_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);
    logic [2*IDX_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (CEN) begin
            if (clr)
                cnt <= '0;
            else if (inc)
                cnt <= cnt + 1'b1;
        end
    end

    assign row  = cnt[2*IDX_W-1:IDX_W];
    assign col  = cnt[IDX_W-1:0];
    assign last = &cnt;
endmodule

// File: rtl/det_matrix_loader.sv
// Streams an 8x8 matrix in row-major order, runs the engine Start/Ack handshake and
// hands the determinant to the consumer. Optional WAIT watchdog: DET_LOADER_TIMEOUT_EN.
module det_matrix_loader
    import det_pkg::*;
#(
    parameter int N              = 8,
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 65535
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [N*N*W-1:0] mat_out,
    output logic             eng_start,
    input  logic             eng_done,
    input  logic [W-1:0]     eng_det,
    output logic             eng_ack,
    output logic             res_valid,
    output logic [W-1:0]     res_det,
    output logic             res_err,
    input  logic             res_ack,
    output logic [4:0]       state_q
);
    if (N != 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("det_matrix_loader: unsupported configuration");
    end

    state_t           state, nxt;
    matrix_t          mat;
    logic             accept;
    logic             last;
    logic             timeout;
    logic [IDX_W-1:0] row, col;

    assign in_ready  = (state == ST_LOAD) && CEN;
    assign accept    = in_valid && in_ready;
    assign eng_start = (state == ST_START);
    assign eng_ack   = (state == ST_ACK);
    assign res_valid = (state == ST_RESULT);
    assign state_q   = state;
    assign mat_out   = mat;

    det_fill_counter u_fill (
        .Clk   (Clk),
        .Reset (Reset),
        .CEN   (CEN),
        .inc   (accept),
        .clr   (state == ST_ACK),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_LOAD;
        else if (CEN)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_LOAD:   if (accept && last) nxt = ST_START;
            ST_START:  nxt = ST_WAIT;
            ST_WAIT:   if (eng_done || timeout) nxt = ST_RESULT;
            ST_RESULT: if (res_ack) nxt = ST_ACK;
            ST_ACK:    nxt = ST_LOAD;
            default:   nxt = ST_LOAD;
        endcase
    end

    // Matrix is only written while loading, so it stays frozen for the engine.
    always_ff @(posedge Clk) begin
        if (Reset)
            mat <= '0;
        else if (accept)
            mat[row][col] <= in_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_det <= '0;
        end else if (CEN && state == ST_WAIT) begin
            if (eng_done)
                res_det <= eng_det;
            else if (timeout)
                res_det <= '0;
        end
    end

`ifdef DET_LOADER_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        err;

    // Counter sits at zero outside WAIT, so it is already cleared on WAIT entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else if (CEN) begin
            if (state != ST_WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 32'd1;
            if (state == ST_WAIT && !eng_done && timeout)
                err <= 1'b1;
            else if (state == ST_ACK)
                err <= 1'b0;
        end
    end

    assign timeout = (state == ST_WAIT) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign res_err = err;
`else
    assign timeout = 1'b0;
    assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed-sequence bench for det_matrix_loader with random matrix data and a
// behavioural engine/consumer model.
module tb_det_matrix_loader;
`ifdef DET_LOADER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65535;
`endif

    logic          Clk = 1'b0;
    logic          Reset, CEN, in_valid, eng_done, res_ack;
    logic [31:0]   in_data, eng_det;
    logic          in_ready, eng_start, eng_ack, res_valid, res_err;
    logic [2047:0] mat_out;
    logic [31:0]   res_det;
    logic [4:0]    state_q;

    int total = 0;
    int bad   = 0;
    logic [31:0] elems [64];

    localparam logic [4:0] S_LOAD = 5'b00001, S_START = 5'b00010, S_WAIT = 5'b00100,
                           S_RESULT = 5'b01000, S_ACK = 5'b10000;

    det_matrix_loader #(.N(8), .W(32), .TIMEOUT_CYCLES(TO)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CEN       (CEN),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mat_out   (mat_out),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .eng_det   (eng_det),
        .eng_ack   (eng_ack),
        .res_valid (res_valid),
        .res_det   (res_det),
        .res_err   (res_err),
        .res_ack   (res_ack),
        .state_q   (state_q)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] elem_at(input int r, input int c);
        return mat_out[(r*8+c)*32 +: 32];
    endfunction

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_mat(input string tag);
        for (int k = 0; k < 64; k++)
            check(tag, elem_at(k / 8, k % 8), elems[k]);
    endtask

    // mode 0: continuous, mode 1: in_valid every other cycle, mode 2: CEN low 10 cycles after 20 accepts
    task automatic fill(input int mode);
        int   k = 0;
        int   cyc = 0;
        int   pause = 0;
        logic acc;
        while (k < 64 && cyc < 2000) begin
            cyc++;
            in_valid = (mode == 1) ? logic'(cyc % 2 == 1) : 1'b1;
            CEN      = !(mode == 2 && k == 20 && pause < 10);
            in_data  = CEN ? elems[k] : ~elems[k];
            if (!CEN) pause++;
            #1;
            check(CEN ? "in_ready_load" : "in_ready_cen_low", in_ready, CEN);
            check("no_early_start", eng_start, 0);
            @(posedge Clk);
            acc = in_valid & in_ready;
            #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        CEN      = 1'b1;
        check("fill_accepts", k, 64);
        if (mode == 0) check("fill_cycles", cyc, 64);
        if (mode == 2) check("pause_cycles", pause, 10);
        check("start_after_fill", eng_start, 1);
        check("state_start", state_q, S_START);
        check_mat("mat_fill");
    endtask

    task automatic engine(input int lat, input logic [31:0] det);
        step;
        check("state_wait", state_q, S_WAIT);
        check("start_one_cycle", eng_start, 0);
        for (int i = 0; i < lat; i++) begin
            eng_done = 1'b0;
            in_valid = (i % 3 == 0);
            in_data  = $urandom;
            res_ack  = (i % 5 == 1);
            step;
            if (i < 4) begin
                check("wait_hold", state_q, S_WAIT);
                check("wait_no_valid", res_valid, 0);
            end
        end
        in_valid = 1'b0;
        res_ack  = 1'b0;
        check_mat("mat_stable_wait");
        eng_done = 1'b1;
        eng_det  = det;
        step;
        eng_done = 1'b0;
        eng_det  = $urandom;
        check("capture_valid", res_valid, 1);
        check("capture_det", res_det, det);
        check("capture_err", res_err, 0);
        check("state_result", state_q, S_RESULT);
    endtask

    task automatic handshake(input int hold, input logic [31:0] det, input logic err);
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("result_hold", res_valid, 1);
        end
        check("result_err", res_err, err);
        res_ack = 1'b1;
        for (int i = 0; i < hold + 3; i++) begin
            if (i == hold) res_ack = 1'b0;
            step;
            if (i == 0) begin
                check("ack_next_cycle", eng_ack, 1);
                check("ack_valid_drop", res_valid, 0);
            end
            if (eng_ack) pulses++;
        end
        res_ack = 1'b0;
        check("ack_pulses", pulses, 1);
        check("back_to_load", state_q, S_LOAD);
        check("ready_after_ack", in_ready, 1);
        check("det_holds", res_det, det);
        check("err_cleared", res_err, 0);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        Reset = 1'b1; CEN = 1'b1; in_valid = 1'b0; in_data = '0;
        eng_done = 1'b0; eng_det = '0; res_ack = 1'b0;
        step; step;
        Reset = 1'b0;
        check("rst_state", state_q, S_LOAD);
        check("rst_ready", in_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_det", res_det, 0);
        check("rst_err", res_err, 0);
        check("rst_start", eng_start, 0);
        check("rst_ack", eng_ack, 0);
        check("rst_mat", 32'(|mat_out), 0);

        // identity, continuous stream, det = 1
        for (int k = 0; k < 64; k++) elems[k] = (k / 8 == k % 8) ? 32'd1 : 32'd0;
        fill(0);
        engine(100, 32'd1);
        handshake(1, 32'd1, 1'b0);

        // element k = k, gapped stream, START stretched by CEN
        for (int k = 0; k < 64; k++) elems[k] = k;
        fill(1);
        check("elem_3_5", elem_at(3, 5), 29);
        check("elem_7_7", elem_at(7, 7), 63);
        CEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("start_stretch", eng_start, 1);
        end
        CEN = 1'b1;
        engine(20, 32'hFFFF_FF85);
        handshake(3, 32'hFFFF_FF85, 1'b0);

        // random data with a CEN pause mid-fill
        for (int k = 0; k < 64; k++) elems[k] = $urandom;
        d = $urandom;
        fill(2);
        engine(7, d);
        handshake(2, d, 1'b0);

        // reset in WAIT, then a stray eng_done
        for (int k = 0; k < 64; k++) elems[k] = $urandom;
        fill(0);
        step;
        check("pre_reset_wait", state_q, S_WAIT);
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        check("midrst_state", state_q, S_LOAD);
        check("midrst_valid", res_valid, 0);
        check("midrst_det", res_det, 0);
        check("midrst_mat", 32'(|mat_out), 0);
        eng_done = 1'b1; eng_det = 32'h1234_5678;
        CEN = 1'b1; in_valid = 1'b0;
        step;
        eng_done = 1'b0;
        check("stray_done_state", state_q, S_LOAD);
        check("stray_done_det", res_det, 0);
        for (int k = 0; k < 64; k++) elems[k] = $urandom;
        d = $urandom;
        fill(0);
        engine(3, d);
        handshake(1, d, 1'b0);

`ifdef DET_LOADER_TIMEOUT_EN
        // watchdog expiry with no eng_done
        for (int k = 0; k < 64; k++) elems[k] = $urandom;
        fill(0);
        step;
        n = 0;
        while (state_q == S_WAIT && n < 200) begin
            n++;
            step;
        end
        check("timeout_wait_cycles", n, 16);
        check("timeout_state", state_q, S_RESULT);
        check("timeout_err", res_err, 1);
        check("timeout_det", res_det, 0);
        handshake(1, 32'd0, 1'b1);
`else
        n = 0;
        check("err_tied_low", res_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
